seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Runtime-programmable serial bit-pattern detector; parametrised successor to the fixed-pattern 3-state detector FSM.
- Pattern length (1..MAX_LEN), pattern value and overlap mode are loaded at runtime.
- Adds an input-valid qualifier, a saturating match counter and a configuration error flag.
- Sits in the fsm benchmark family, fed by a serial bit stream, one bit per qualified clock.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of CFG_LEN; must hold MAX_LEN (>= clog2(MAX_LEN+1)).
- CNT_W, 8: width of MATCH_CNT.
- DEF_PATTERN, 8'b11100011: pattern after reset, LSB-aligned.
- DEF_LEN, 8: pattern length after reset.
- DEF_OVERLAP, 1: overlap mode after reset.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- IN  input  1  serial data bit.
- IN_VALID  input  1  IN is sampled only when 1.
- CFG_LOAD  input  1  single-cycle pulse; latches CFG_* fields.
- CFG_PATTERN  input  MAX_LEN  pattern, LSB-aligned. First-received bit = CFG_PATTERN[CFG_LEN-1].
- CFG_LEN  input  LEN_W  pattern length.
- CFG_OVERLAP  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_CLR  input  1  clears MATCH_CNT.
- MATCH  output  1  one-cycle pulse per detected pattern.
- MATCH_CNT  output  CNT_W  saturating count of matches.
- CFG_ERR  output  1  one-cycle pulse: rejected configuration.

Behaviour:
- Reset (RST=0, async): history=0, fill=0, state=HUNT, pattern/len/overlap = DEF_*, MATCH=0, MATCH_CNT=0, CFG_ERR=0.
- Datapath:
  - history is a MAX_LEN-bit shift register; on an accepted bit, history <= {history[MAX_LEN-2:0], IN}.
  - fill counts accepted bits since the last restart and saturates at the active length.
- FSM, two states:
  - HUNT: fill < len. Accepted bit increments fill; go to ARMED when fill reaches len.
  - ARMED: fill == len. A compare happens on every accepted bit.
- Match condition: the accepted bit makes history[len-1:0] == pattern[len-1:0] while fill (after increment) >= len.
  - MATCH is registered: it is 1 for exactly the cycle following the sampling edge of the completing bit. No combinational path from IN.
- Overlap = 1: history is kept after a match; the next match can occur on the very next bit (e.g. pattern 11, input 111 gives 2 matches).
- Overlap = 0: on a match, fill <= 0 and state <= HUNT. The following len bits are required before the next match.
- IN_VALID = 0: no shift, no compare, MATCH = 0, state held. Gaps are transparent to the pattern.
- CFG_LOAD:
  - Valid when 1 <= CFG_LEN <= MAX_LEN. Latches pattern, len and overlap; clears history and fill; state = HUNT. MATCH_CNT is unaffected.
  - Invalid CFG_LEN (0 or > MAX_LEN): old configuration kept, history untouched, CFG_ERR = 1 for one cycle.
- Simultaneous CFG_LOAD and IN_VALID: CFG_LOAD wins, the IN bit is discarded, MATCH = 0. This holds even if the load is rejected.
- MATCH_CNT increments on each MATCH and saturates at 2^CNT_W-1.
- CNT_CLR with a simultaneous match: clear takes effect first, so count = 1.
- Reset mid-stream: all state drops to reset values immediately; no MATCH is emitted for partial history.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum (HUNT, ARMED);
  - DEF_PATTERN/DEF_LEN defaults;
  - a localparam function for the width check of LEN_W against MAX_LEN.
- One natural sub-module: seq_hist_cmp. It contains the shift register plus masked compare of the low len bits and outputs a hit flag.
- The FSM, config registers and counter stay in the top.

Test Plan:
- Reset defaults, IN_VALID=1, stream 1,1,1,0,0,0,1,1 -> MATCH=1 exactly in the cycle after the 8th bit, MATCH_CNT=1, no earlier MATCH.
- Load pattern 3'b101, len 3, overlap=1; stream 1,0,1,0,1 -> MATCH after bits 3 and 5, MATCH_CNT=2. Repeat with overlap=0 -> MATCH after bit 3 only, MATCH_CNT=1.
- Default pattern, IN_VALID dropped for 3 cycles between bits 4 and 5 -> MATCH still after the 8th valid bit. MATCH=0 during gaps.
- CFG_LOAD with CFG_LEN=0, then with CFG_LEN=MAX_LEN+1 -> CFG_ERR pulses twice. Default pattern still detected afterwards.
- CFG_LOAD in the same cycle as the last bit of a pending match -> no MATCH, fill restarts. RST=0 asserted mid-pattern -> MATCH_CNT=0 and outputs low immediately.
- CNT_W=2, pattern 1 len 1, overlap=1, stream of 5 ones -> MATCH_CNT saturates at 3. CNT_CLR on a match cycle -> MATCH_CNT=1.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the runtime-programmable serial pattern detector.
//   state_e       : detector FSM states (hunting for a full window / armed and comparing)
//   DEF_PATTERN   : pattern loaded at reset, LSB-aligned (first-received bit is the MSB)
//   DEF_LEN       : pattern length loaded at reset
//   len_w_fits()  : checks that a LenW-bit length field can hold the value MaxLen
package seq_detect_pkg;

    typedef enum logic {
        StHunt  = 1'b0,
        StArmed = 1'b1
    } state_e;

    localparam logic [31:0] DEF_PATTERN = 32'h0000_00E3;
    localparam int unsigned DEF_LEN     = 8;

    function automatic bit len_w_fits(input int unsigned max_len, input int unsigned len_w);
        if (len_w >= 32) begin
            return 1'b1;
        end
        return max_len < (32'd1 << len_w);
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Signal bundle between a stream/config source and the pattern detector.
//   in_i, in_valid_i          : serial data bit and its qualifier
//   cfg_load_i, cfg_pattern_i,
//   cfg_len_i, cfg_overlap_i  : single-cycle configuration load
//   cnt_clr_i                 : clears the match counter
//   match_o, match_cnt_o      : registered match pulse and saturating match count
//   cfg_err_o                 : one-cycle pulse for a rejected configuration
// Modports: master drives the stream/config side, slave is the detector.
interface seq_detect_param_if #(
    parameter int unsigned MaxLen = 8,
    parameter int unsigned LenW   = 4,
    parameter int unsigned CntW   = 8
);

    logic              in_i;
    logic              in_valid_i;
    logic              cfg_load_i;
    logic [MaxLen-1:0] cfg_pattern_i;
    logic [LenW-1:0]   cfg_len_i;
    logic              cfg_overlap_i;
    logic              cnt_clr_i;
    logic              match_o;
    logic [CntW-1:0]   match_cnt_o;
    logic              cfg_err_o;

    modport master (
        output in_i, in_valid_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cnt_clr_i,
        input  match_o, match_cnt_o, cfg_err_o
    );

    modport slave (
        input  in_i, in_valid_i, cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i, cnt_clr_i,
        output match_o, match_cnt_o, cfg_err_o
    );

endinterface

// File: rtl/seq_hist_cmp.sv
// Serial history shift register with a masked compare of the low len_i bits.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   shift_i       : accept bit_i into the history this cycle
//   bit_i         : incoming serial bit
//   clear_i       : zero the history (takes priority over shift_i)
//   len_i         : active pattern length, 1..MaxLen
//   pattern_i     : active pattern, LSB-aligned
//   hit_o         : history *after* shifting bit_i in matches the pattern (combinational)
module seq_hist_cmp #(
    parameter int unsigned MaxLen = 8,
    parameter int unsigned LenW   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_i,
    input  logic              bit_i,
    input  logic              clear_i,
    input  logic [LenW-1:0]   len_i,
    input  logic [MaxLen-1:0] pattern_i,
    output logic              hit_o
);

    // The oldest history bit is never compared again once shifted, so only MaxLen-1 bits are
    // stored; the full MaxLen-bit window is rebuilt from them plus the incoming bit.
    logic [MaxLen-2:0] hist_q, hist_d;
    logic [MaxLen-1:0] hist_shift;
    logic [MaxLen-1:0] mask;

    assign hist_shift = {hist_q, bit_i};

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(MaxLen); i++) begin
            mask[i] = (i < int'(len_i));
        end
    end

    assign hit_o = (((hist_shift ^ pattern_i) & mask) == '0);

    always_comb begin
        hist_d = hist_q;
        if (clear_i) begin
            hist_d = '0;
        end else if (shift_i) begin
            hist_d = hist_shift[MaxLen-2:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-pattern detector.
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   det_io        : stream, configuration and result bundle (slave side)
// A valid bit shifts into the history; once len bits have arrived since the last restart every
// further bit is compared. A config load takes priority over a same-cycle data bit, which is
// then discarded even if the load is rejected.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned       MaxLen     = 8,
    parameter int unsigned       LenW       = 4,
    parameter int unsigned       CntW       = 8,
    parameter logic [MaxLen-1:0] DefPattern = MaxLen'(DEF_PATTERN),
    parameter int unsigned       DefLen     = DEF_LEN,
    parameter bit                DefOverlap = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    seq_detect_param_if.slave  det_io
);

    if (!len_w_fits(MaxLen, LenW) || MaxLen < 2 || MaxLen > 32) begin : g_bad_params
        $error("seq_detect_param: MaxLen must be 2..32 and fit in LenW bits");
    end

    state_e            state_q, state_d;
    logic [LenW-1:0]   fill_q, fill_d, fill_inc;
    logic [MaxLen-1:0] pattern_q, pattern_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              overlap_q, overlap_d;
    logic              match_q, match_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic cfg_ok, load_ok, load_bad, accept, hist_clr, hit;

    assign cfg_ok   = (det_io.cfg_len_i != '0) && (32'(det_io.cfg_len_i) <= MaxLen);
    assign load_ok  = det_io.cfg_load_i & cfg_ok;
    assign load_bad = det_io.cfg_load_i & ~cfg_ok;
    assign accept   = det_io.in_valid_i & ~det_io.cfg_load_i;

    seq_hist_cmp #(
        .MaxLen (MaxLen),
        .LenW   (LenW)
    ) u_hist_cmp (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .shift_i   (accept),
        .bit_i     (det_io.in_i),
        .clear_i   (hist_clr),
        .len_i     (len_q),
        .pattern_i (pattern_q),
        .hit_o     (hit)
    );

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        match_d   = 1'b0;
        hist_clr  = 1'b0;
        fill_inc  = fill_q + 1'b1;

        if (load_ok) begin
            pattern_d = det_io.cfg_pattern_i;
            len_d     = det_io.cfg_len_i;
            overlap_d = det_io.cfg_overlap_i;
            fill_d    = '0;
            state_d   = StHunt;
            hist_clr  = 1'b1;
        end else if (accept) begin
            unique case (state_q)
                StHunt: begin
                    fill_d = fill_inc;
                    if (fill_inc == len_q) begin
                        state_d = StArmed;
                        match_d = hit;
                    end
                end
                StArmed: begin
                    // fill stays saturated at len while armed
                    match_d = hit;
                end
                default: ;
            endcase
            if (match_d && !overlap_q) begin
                fill_d  = '0;
                state_d = StHunt;
            end
        end
    end

    // Clear is applied before a same-cycle match increment, so clear+match leaves a count of 1.
    always_comb begin
        cnt_d = det_io.cnt_clr_i ? '0 : cnt_q;
        if (match_d && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end
        err_d = load_bad;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StHunt;
            fill_q    <= '0;
            pattern_q <= DefPattern;
            len_q     <= LenW'(DefLen);
            overlap_q <= DefOverlap;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign det_io.match_o     = match_q;
    assign det_io.match_cnt_o = cnt_q;
    assign det_io.cfg_err_o   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: one default-width instance and one with a 2-bit counter.
module tb_seq_detect_param;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_detect_param_if #(.MaxLen(8), .LenW(4), .CntW(8)) u_if ();
    seq_detect_param_if #(.MaxLen(8), .LenW(4), .CntW(2)) u_if2 ();

    seq_detect_param #(.MaxLen(8), .LenW(4), .CntW(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .det_io (u_if)
    );

    seq_detect_param #(.MaxLen(8), .LenW(4), .CntW(2)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .det_io (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic v);
        u_if.in_i       = b;
        u_if.in_valid_i = v;
        u_if.cfg_load_i = 1'b0;
        u_if.cnt_clr_i  = 1'b0;
        step();
    endtask

    task automatic clear_cnt();
        u_if.in_valid_i = 1'b0;
        u_if.cfg_load_i = 1'b0;
        u_if.cnt_clr_i  = 1'b1;
        step();
        u_if.cnt_clr_i  = 1'b0;
        chk("cnt_clr", u_if.match_cnt_o, 0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                        input logic b, input logic v);
        u_if.cfg_pattern_i = pat;
        u_if.cfg_len_i     = len;
        u_if.cfg_overlap_i = ov;
        u_if.cfg_load_i    = 1'b1;
        u_if.in_i          = b;
        u_if.in_valid_i    = v;
        u_if.cnt_clr_i     = 1'b0;
        step();
        u_if.cfg_load_i    = 1'b0;
        u_if.in_valid_i    = 1'b0;
    endtask

    // Sends seq[n-1] first; exp[i] is the MATCH expected after sending seq[i].
    task automatic stream(input string tag, input logic [31:0] seq, input logic [31:0] exp,
                          input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(seq[i], 1'b1);
            chk(tag, u_if.match_o, exp[i]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        u_if.in_i = 1'b0;  u_if.in_valid_i = 1'b0; u_if.cfg_load_i = 1'b0;
        u_if.cfg_pattern_i = '0; u_if.cfg_len_i = '0; u_if.cfg_overlap_i = 1'b0;
        u_if.cnt_clr_i = 1'b0;
        u_if2.in_i = 1'b0; u_if2.in_valid_i = 1'b0; u_if2.cfg_load_i = 1'b0;
        u_if2.cfg_pattern_i = '0; u_if2.cfg_len_i = '0; u_if2.cfg_overlap_i = 1'b0;
        u_if2.cnt_clr_i = 1'b0;

        #12;
        chk("rst_match", u_if.match_o, 0);
        chk("rst_cnt", u_if.match_cnt_o, 0);
        chk("rst_err", u_if.cfg_err_o, 0);
        rst_n = 1'b1;

        // Default pattern 11100011
        stream("def", 32'hE3, 32'h01, 8);
        chk("def_cnt", u_if.match_cnt_o, 1);
        send(1'b1, 1'b0);
        chk("def_idle", u_if.match_o, 0);

        // 101 with and without overlap
        clear_cnt();
        load(8'h05, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("ld_ok_err", u_if.cfg_err_o, 0);
        stream("ov1", 32'b10101, 32'b00101, 5);
        chk("ov1_cnt", u_if.match_cnt_o, 2);
        clear_cnt();
        load(8'h05, 4'd3, 1'b0, 1'b0, 1'b0);
        stream("ov0", 32'b10101, 32'b00100, 5);
        chk("ov0_cnt", u_if.match_cnt_o, 1);

        // Gaps in IN_VALID are transparent
        load(8'hE3, 4'd8, 1'b1, 1'b0, 1'b0);
        clear_cnt();
        stream("gap_a", 32'b1110, 32'b0000, 4);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            chk("gap_idle", u_if.match_o, 0);
        end
        stream("gap_b", 32'b0011, 32'b0001, 4);
        chk("gap_cnt", u_if.match_cnt_o, 1);

        // Rejected lengths 0 and MaxLen+1; same-cycle bit is discarded, config kept
        load(8'h55, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("err0", u_if.cfg_err_o, 1);
        chk("err0_match", u_if.match_o, 0);
        send(1'b0, 1'b0);
        chk("err0_pulse", u_if.cfg_err_o, 0);
        load(8'h55, 4'd9, 1'b0, 1'b0, 1'b0);
        chk("err9", u_if.cfg_err_o, 1);
        send(1'b0, 1'b0);
        chk("err9_pulse", u_if.cfg_err_o, 0);
        stream("after_err", 32'hE3, 32'h01, 8);
        chk("after_err_cnt", u_if.match_cnt_o, 2);

        // Load on the completing bit of a pending match: no match, fill restarts
        stream("pend", 32'b1110001, 32'b0, 7);
        load(8'h01, 4'd8, 1'b1, 1'b1, 1'b1);
        chk("pend_match", u_if.match_o, 0);
        chk("pend_err", u_if.cfg_err_o, 0);
        chk("pend_cnt", u_if.match_cnt_o, 2);
        stream("refill", 32'b100000001, 32'b000000001, 9);
        chk("refill_cnt", u_if.match_cnt_o, 3);

        // Asynchronous reset while MATCH is high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_match", u_if.match_o, 0);
        chk("arst_cnt", u_if.match_cnt_o, 0);
        chk("arst_err", u_if.cfg_err_o, 0);
        #1 rst_n = 1'b1;

        // Reset mid-pattern drops partial history; defaults restored
        stream("rst_a", 32'b1110, 32'b0, 4);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        stream("rst_b", 32'b0011, 32'b0, 4);
        stream("rst_c", 32'hE3, 32'h01, 8);
        chk("rst_c_cnt", u_if.match_cnt_o, 1);

        // 2-bit counter saturation and clear-with-match
        u_if2.cfg_pattern_i = 8'h01;
        u_if2.cfg_len_i     = 4'd1;
        u_if2.cfg_overlap_i = 1'b1;
        u_if2.cfg_load_i    = 1'b1;
        step();
        u_if2.cfg_load_i    = 1'b0;
        chk("sat_ld_cnt", u_if2.match_cnt_o, 0);
        for (int i = 1; i <= 5; i++) begin
            u_if2.in_i       = 1'b1;
            u_if2.in_valid_i = 1'b1;
            step();
            chk("sat_match", u_if2.match_o, 1);
            chk("sat_cnt", u_if2.match_cnt_o, (i > 3) ? 3 : i);
        end
        u_if2.cnt_clr_i = 1'b1;
        step();
        chk("clr_hit_match", u_if2.match_o, 1);
        chk("clr_hit_cnt", u_if2.match_cnt_o, 1);
        u_if2.cnt_clr_i  = 1'b0;
        u_if2.in_valid_i = 1'b0;
        step();
        chk("clr_idle_match", u_if2.match_o, 0);
        chk("clr_idle_cnt", u_if2.match_cnt_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
